dmi_responder: RTL

//  DMI target-side front end of the debug module. Accepts debugger DMI requests (valid/ready),

---
 rtl/dmi_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmi_responder.sv
// DMI target-side front end: accepts one debugger request at a time, runs it on the DM
// register bus with an ack/err/timeout handshake, and returns a single-cycle response.
module dmi_responder #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmi_req_valid_i,
  input  logic [1:0]        dmi_req_op_i,
  input  logic [ADDR_W-1:0] dmi_req_address_i,
  input  logic [DATA_W-1:0] dmi_req_data_i,
  output logic              dmi_req_ready_o,
  output logic              dmi_rsp_valid_o,
  output logic [1:0]        dmi_rsp_op_o,
  output logic [DATA_W-1:0] dmi_rsp_data_o,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  input  logic              reg_ack_i,
  input  logic              reg_err_i,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic              sticky_err_clr_i,
  output logic              sticky_err_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;
  localparam logic [1:0] RspOk   = 2'b00;
  localparam logic [1:0] RspFail = 2'b10;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic [1:0]          rsp_op_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                reg_req_q;
  logic                reg_we_q;
  logic [ADDR_W-1:0]   reg_addr_q;
  logic [DATA_W-1:0]   reg_wdata_q;
  logic                sticky_q;
  logic                accept;
  logic                sticky_set;

  assign accept = (state_q == StIdle) && ready_q && dmi_req_valid_i;

  // Failure events that latch the sticky flag; these take priority over a clear.
  always_comb begin
    sticky_set = 1'b0;
    unique case (state_q)
      StIdle:   sticky_set = accept && (dmi_req_op_i == OpRsvd);
      StAccess: sticky_set = reg_err_i || (!reg_ack_i && (timer_q == TimerMax));
      default:  sticky_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= RspOk;
      rsp_data_q  <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (sticky_set) begin
        sticky_q <= 1'b1;
      end else if (sticky_err_clr_i) begin
        sticky_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q     <= 1'b0;
            reg_addr_q  <= dmi_req_address_i;
            reg_wdata_q <= dmi_req_data_i;
            reg_we_q    <= (dmi_req_op_i == OpWrite);
            if (dmi_req_op_i == OpNop) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_op_q    <= RspOk;
              rsp_data_q  <= '0;
            end else if (dmi_req_op_i == OpRsvd || sticky_q) begin
              // Fail fast: a pending error blocks the register bus until cleared.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_op_q    <= RspFail;
              rsp_data_q  <= '0;
            end else begin
              state_q   <= StAccess;
              reg_req_q <= 1'b1;
              timer_q   <= TimerW'(1);
            end
          end
        end

        StAccess: begin
          if (reg_err_i || reg_ack_i || (timer_q == TimerMax)) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            reg_req_q   <= 1'b0;
            timer_q     <= '0;
            if (!reg_err_i && reg_ack_i) begin
              rsp_op_q   <= RspOk;
              rsp_data_q <= reg_we_q ? '0 : reg_rdata_i;
            end else begin
              rsp_op_q   <= RspFail;
              rsp_data_q <= '0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end

        default: begin
          state_q   <= StIdle;
          reg_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmi_req_ready_o = ready_q;
  assign dmi_rsp_valid_o = rsp_valid_q;
  assign dmi_rsp_op_o    = rsp_op_q;
  assign dmi_rsp_data_o  = rsp_data_q;
  assign reg_req_o       = reg_req_q;
  assign reg_we_o        = reg_we_q;
  assign reg_addr_o      = reg_addr_q;
  assign reg_wdata_o     = reg_wdata_q;
  assign sticky_err_o    = sticky_q;

endmodule
